decode_stage: RTL and testbench

Parametrised, pipelined successor to the combinational D-stage field splitter. Accepts fetched instructions over a valid/ready handshake and splits each into opcode, operand A/B, data-memory address and destination. Results are registered into a 2-entry skid buffer feeding the X stage. Adds flush, a wrapping decoded-instruction counter, and an optional load-use interlock.

---
 rtl/decode_stage.sv | 139 +++++++++++++
 tb/tb_decode_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Pipelined D-stage field splitter with a 2-entry skid buffer, flush and decoded-instruction counter.
// Optional load-use interlock enabled by defining DECODE_HAZARD_EN.
module decode_stage #(
    parameter int unsigned           OPC_W     = 4,
    parameter int unsigned           REG_W     = 3,
    parameter int unsigned           ADDR_W    = 4,
    parameter logic [OPC_W-1:0]      MEM_OPC   = 4'hF,
    parameter logic [OPC_W-1:0]      NOOPR_OPC = 4'hE,
    parameter int unsigned           CNT_W     = 16,
    localparam int unsigned          INST_W    = OPC_W + 3*REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  operanda,
    output logic [REG_W-1:0]  operandb,
    output logic [ADDR_W-1:0] dmaddr,
    output logic [REG_W-1:0]  dest,
    output logic              is_mem,
    output logic              stall,
    output logic [CNT_W-1:0]  inst_count
);

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [REG_W-1:0]  opa;
        logic [REG_W-1:0]  opb;
        logic [ADDR_W-1:0] dma;
        logic [REG_W-1:0]  dst;
        logic              mem;
    } dec_t;

    logic [OPC_W-1:0] fld_opc;
    logic [REG_W-1:0] fld_a;
    logic [REG_W-1:0] fld_b;
    logic             no_regs;
    dec_t             dec;

    dec_t main_q;
    dec_t skid_q;
    logic main_v;
    logic skid_v;
    logic stall_cond;
    logic accept;
    logic drain;

    assign fld_opc = in_inst[INST_W-1 -: OPC_W];
    assign fld_a   = in_inst[INST_W-OPC_W-1 -: REG_W];
    assign fld_b   = in_inst[INST_W-OPC_W-REG_W-1 -: REG_W];

    always_comb begin
        dec     = '0;
        dec.opc = fld_opc;
        dec.mem = (fld_opc == MEM_OPC);
        no_regs = dec.mem || (fld_opc == NOOPR_OPC);
        dec.opa = no_regs ? '0 : fld_a;
        dec.opb = no_regs ? '0 : fld_b;
        dec.dma = dec.mem ? in_inst[INST_W-OPC_W-1 -: ADDR_W] : '0;
        dec.dst = in_inst[REG_W-1:0];
    end

`ifdef DECODE_HAZARD_EN
    logic [REG_W-1:0] trk_dest;
    logic             trk_mem;

    assign stall_cond = in_valid && trk_mem && !no_regs &&
                        ((fld_a == trk_dest) || (fld_b == trk_dest));

    // A stall retires the tracker to a bubble so the held instruction goes next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_dest <= '0;
            trk_mem  <= 1'b0;
        end else if (flush || (stall_cond && !accept)) begin
            trk_dest <= '0;
            trk_mem  <= 1'b0;
        end else if (accept) begin
            trk_dest <= dec.dst;
            trk_mem  <= dec.mem;
        end
    end
`else
    assign stall_cond = 1'b0;
`endif

    assign in_ready = !skid_v && !stall_cond && !flush;
    assign accept   = in_valid && in_ready;
    assign drain    = main_v && out_ready;

    // Skid is only ever occupied while main is held, so an empty main implies an empty skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (main_v && !drain) begin
            if (accept) begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end else if (skid_v) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
        end else if (accept) begin
            main_q <= dec;
            main_v <= 1'b1;
        end else begin
            main_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_count <= '0;
        end else if (accept) begin
            inst_count <= inst_count + 1'b1;
        end
    end

    assign out_valid = main_v;
    assign opcode    = main_q.opc;
    assign operanda  = main_q.opa;
    assign operandb  = main_q.opb;
    assign dmaddr    = main_q.dma;
    assign dest      = main_q.dst;
    assign is_mem    = main_q.mem;
    assign stall     = stall_cond;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [12:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [2:0]  operanda;
    logic [2:0]  operandb;
    logic [3:0]  dmaddr;
    logic [2:0]  dest;
    logic        is_mem;
    logic        stall;
    logic [15:0] inst_count;

    logic        rdy4, ov4, mem4, stall4;
    logic [3:0]  opc4, dm4, cnt4;
    logic [2:0]  a4, b4, d4;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .operanda(operanda), .operandb(operandb), .dmaddr(dmaddr), .dest(dest),
        .is_mem(is_mem), .stall(stall), .inst_count(inst_count)
    );

    decode_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_ready(rdy4),
        .flush(flush), .out_valid(ov4), .out_ready(out_ready), .opcode(opc4),
        .operanda(a4), .operandb(b4), .dmaddr(dm4), .dest(d4),
        .is_mem(mem4), .stall(stall4), .inst_count(cnt4)
    );

`ifdef DECODE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct {
        int opc; int a; int b; int dm; int dst; int mem;
    } exp_t;

    typedef struct {
        logic [12:0] inst;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    int   m_cnt;
    int   trk_dest;
    bit   trk_mem;
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic exp_t decode_ref(input int inst);
        exp_t e;
        bit noreg;
        e.opc = inst / 512;
        e.mem = (e.opc == 15) ? 1 : 0;
        noreg = (e.opc == 15) || (e.opc == 14);
        e.a   = noreg ? 0 : (inst / 64) % 8;
        e.b   = noreg ? 0 : (inst / 8) % 8;
        e.dm  = (e.mem == 1) ? (inst / 32) % 16 : 0;
        e.dst = inst % 8;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt    = 0;
        trk_dest = 0;
        trk_mem  = 1'b0;
    endtask

    task automatic step(input logic iv, input logic [12:0] inst, input logic ordy, input logic fl);
        exp_t e;
        bit   stall_m, rdy_m, drain_m;
        in_valid  = iv;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        e       = decode_ref(int'(inst));
        stall_m = HZ && iv && trk_mem && !(e.opc == 15 || e.opc == 14) &&
                  (((int'(inst) / 64) % 8 == trk_dest) || ((int'(inst) / 8) % 8 == trk_dest));
        rdy_m   = (q.size() < 2) && !fl && !stall_m;
        drain_m = (q.size() > 0) && ordy;
        chk("in_ready", int'(in_ready), int'(rdy_m));
        chk("stall", int'(stall), int'(stall_m));
        chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
        chk("inst_count", int'(inst_count), m_cnt % 65536);
        chk("inst_count4", int'(cnt4), m_cnt % 16);
        if (q.size() > 0) begin
            chk("opcode", int'(opcode), q[0].opc);
            chk("operanda", int'(operanda), q[0].a);
            chk("operandb", int'(operandb), q[0].b);
            chk("dmaddr", int'(dmaddr), q[0].dm);
            chk("dest", int'(dest), q[0].dst);
            chk("is_mem", int'(is_mem), q[0].mem);
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
            trk_dest = 0;
            trk_mem  = 1'b0;
        end else begin
            if (drain_m) void'(q.pop_front());
            if (iv && rdy_m) begin
                q.push_back(e);
                m_cnt++;
                trk_dest = e.dst;
                trk_mem  = e.mem[0];
            end else if (stall_m) begin
                trk_dest = 0;
                trk_mem  = 1'b0;
            end
        end
        #1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{13'h0053, '{0, 1, 2, 0, 3, 0}};
        vecs[1] = '{13'h1F45, '{15, 0, 0, 10, 5, 1}};
        vecs[2] = '{13'h1DEF, '{14, 0, 0, 0, 7, 0}};
        vecs[3] = '{13'h0FFF, '{7, 7, 7, 0, 7, 0}};
        vecs[4] = '{13'h1E00, '{15, 0, 0, 0, 0, 1}};
        vecs[5] = '{13'h1FFF, '{15, 0, 0, 15, 7, 1}};
        vecs[6] = '{13'h0A49, '{5, 1, 1, 0, 1, 0}};

        rst = 1'b1; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_dest", int'(dest), 0);
        chk("rst_dmaddr", int'(dmaddr), 0);
        chk("rst_is_mem", int'(is_mem), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_count", int'(inst_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", int'(in_ready), 1);

        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].inst, 1'b1, 1'b0);
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_opcode", int'(opcode), vecs[i].e.opc);
            chk("vec_operanda", int'(operanda), vecs[i].e.a);
            chk("vec_operandb", int'(operandb), vecs[i].e.b);
            chk("vec_dmaddr", int'(dmaddr), vecs[i].e.dm);
            chk("vec_dest", int'(dest), vecs[i].e.dst);
            chk("vec_is_mem", int'(is_mem), vecs[i].e.mem);
            chk("vec_count", int'(inst_count), i + 1);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 13'h0000, 1'b1, 1'b0);
        chk("wrap_count4", int'(cnt4), 1);
        chk("wrap_count16", int'(inst_count), 17);

        // Backpressure: main + skid fill, third is refused, then in-order drain.
        step(1'b0, 13'h0000, 1'b1, 1'b0);
        step(1'b1, 13'h0401, 1'b0, 1'b0);
        step(1'b1, 13'h0602, 1'b0, 1'b0);
        in_valid = 1'b1; in_inst = 13'h0803; #1;
        chk("bp_full_ready", int'(in_ready), 0);
        chk("bp_head_opcode", int'(opcode), 2);
        step(1'b1, 13'h0803, 1'b0, 1'b0);
        chk("bp_hold_opcode", int'(opcode), 2);
        step(1'b0, 13'h0000, 1'b1, 1'b0);
        chk("bp_second_opcode", int'(opcode), 3);
        chk("bp_second_dest", int'(dest), 2);
        chk("bp_ready_back", int'(in_ready), 1);
        step(1'b0, 13'h0000, 1'b1, 1'b0);
        chk("bp_empty", int'(out_valid), 0);
        chk("bp_count", int'(inst_count), 19);

        // Flush with both entries full.
        step(1'b1, 13'h0C04, 1'b0, 1'b0);
        step(1'b1, 13'h0E05, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_inst = 13'h0005; #1;
        chk("flush_ready", int'(in_ready), 0);
        step(1'b1, 13'h0005, 1'b0, 1'b1);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_count", int'(inst_count), 21);
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("flush_ready_after", int'(in_ready), 1);

        // Load followed by a dependent instruction.
        step(1'b1, 13'h1F45, 1'b1, 1'b0);
        in_valid = 1'b1; in_inst = 13'h014A; out_ready = 1'b1; #1;
`ifdef DECODE_HAZARD_EN
        chk("hz_stall", int'(stall), 1);
        chk("hz_ready", int'(in_ready), 0);
        step(1'b1, 13'h014A, 1'b1, 1'b0);
        chk("hz_stall_clear", int'(stall), 0);
        chk("hz_ready_back", int'(in_ready), 1);
        step(1'b1, 13'h014A, 1'b1, 1'b0);
`else
        chk("hz_stall", int'(stall), 0);
        chk("hz_ready", int'(in_ready), 1);
        step(1'b1, 13'h014A, 1'b1, 1'b0);
`endif
        chk("hz_operanda", int'(operanda), 5);
        chk("hz_count", int'(inst_count), 23);
        step(1'b0, 13'h0000, 1'b1, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int opc, a, b, d, r;
            r   = $urandom_range(0, 7);
            opc = (r == 0) ? 15 : (r == 1) ? 14 : $urandom_range(0, 15);
            a   = $urandom_range(0, 7);
            b   = $urandom_range(0, 7);
            d   = $urandom_range(0, 7);
            step(($urandom_range(0, 9) < 7), 13'(opc * 512 + a * 64 + b * 8 + d),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
